maxpool_datapath: RTL and testbench
===================================

// Module: maxpool_datapath
// PURPOSE
//  Max-pooling datapath driven cycle-by-cycle by the pooling control FSM (sel/rst_m/op_en/load_sr/global_rst/end_op).
//  Compares the incoming conv-layer pixel stream against running maxima, keeps per-window partial maxima for one row in a shift buffer.
//  Emits one pooled result per PxP window into an output FIFO with valid/ready handshake toward the next layer.
// PARAMETERS
//  N          16  pixel width, two's-complement signed
//  M          4   input feature-map width/height in pixels; M % P == 0
//  P          2   pooling window size (P x P, stride P)
//  FIFO_DEPTH 4   output FIFO entries, power of two, >= 2
// PORTS
//  clk          in   1   single clock, rising edge
//  master_rst   in   1   asynchronous, active-high reset
//  ce           in   1   pixel strobe; all datapath state advances only when ce=1
//  din          in   N   input pixel, valid when ce=1
//  sel          in   2   candidate mux: 00 max_r, 01 row-buffer head, 10 MIN_VAL, 11 MIN_VAL
//  rst_m        in   1   restart running max (window boundary)
//  op_en        in   1   current comparison completes a window -> push result
//  load_sr      in   1   push comparison result into row buffer
//  global_rst   in   1   active-low synchronous frame clear (qualified by ce)
//  end_op       in   1   frame finished indication from control
//  dout         out  N   FIFO head, pooled max
//  dout_valid   out  1   FIFO non-empty
//  dout_ready   in   1   consumer accepts dout when dout_valid & dout_ready
//  fifo_full    out  1   FIFO holds FIFO_DEPTH entries
//  overflow     out  1   sticky: push attempted while full
//  frame_done   out  1   one-cycle pulse, registered end_op & ce
// BEHAVIOUR
//  Reset (master_rst=1, any time, async): max_r=MIN_VAL, row buffer all MIN_VAL, FIFO empty, dout=0,
//   dout_valid=0, fifo_full=0, overflow=0, frame_done=0. Mid-frame reset drops all partial and queued data.
//  Combinational: cand = mux(sel); cmp = ($signed(din) > $signed(cand)) ? din : cand. Ties keep cand.
//  Row buffer: D = M/P entries of N bits, head = oldest entry. On ce & load_sr: shift in cmp, head advances.
//  Running max, on ce: rst_m -> max_r <= MIN_VAL; else max_r <= cmp. rst_m wins over update.
//  Push: on ce & op_en, cmp written to FIFO tail. Latency: din to dout_valid = 1 cycle when FIFO was empty.
//  Pop: dout_valid & dout_ready. Simultaneous push+pop when full: both succeed, occupancy unchanged, no overflow.
//  Push while full without pop: data dropped, overflow <= 1, sticky until master_rst.
//  Pop while empty: ignored. dout is registered head; shows 0 when empty.
//  global_rst=0 with ce=1: next edge max_r and all row-buffer entries <= MIN_VAL; FIFO untouched;
//   a same-cycle op_en push still completes using the pre-clear cmp.
//  ce=0: max_r, row buffer and frame_done hold/clear (frame_done=0); FIFO pop side remains live.
//  frame_done: registered pulse the cycle after ce & end_op; never held two cycles for a single strobe.
//  Widths: occupancy counter $clog2(FIFO_DEPTH)+1 bits; read/write pointers wrap modulo FIFO_DEPTH.
// STRUCTURE
//  cnn_pkg: MIN_VAL (signed N-bit minimum, 1<<(N-1)), SEL_MAX/SEL_SR/SEL_MIN encodings, clog2 helper.
//  Sub-module pool_out_fifo (sync FIFO, width N, depth FIFO_DEPTH, full/empty/count, overflow flag).
//  Row buffer, mux, comparator and max_r stay in this module.
// TESTING
//  Reset: assert master_rst mid-stream with 3 entries queued -> dout_valid=0, overflow=0, max_r=0x8000 immediately.
//  Compare: N=16, sel=10, din=-3 (0xFFFD), op_en=1 -> dout=0xFFFD next cycle; tie din=cand=7 keeps 7.
//  4x4 frame, P=2, rows [1,5,2,3],[4,0,7,6],[9,8,-1,-2],[3,2,-4,-5] with control FSM stimulus -> dout sequence 5,7,9,-1.
//  Backpressure: dout_ready=0, 5 op_en pushes at FIFO_DEPTH=4 -> fifo_full=1, overflow=1, pops return first 4 only.
//  Full + simultaneous push/pop with dout_ready=1 -> occupancy stays 4, overflow stays 0, order preserved.
//  global_rst=0 with ce mid-row -> next window result ignores prior partial maxima; frame_done pulses once per end_op.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared definitions for the pooling datapath: candidate-select encodings,
// the most negative pixel value and a constant log2 helper.
package cnn_pkg;

    localparam int N_DEF = 16;

    // Most negative signed pixel value at the default pixel width.
    localparam logic [N_DEF-1:0] MIN_VAL = {1'b1, {(N_DEF-1){1'b0}}};

    // Candidate mux encodings driven by the pooling control FSM.
    typedef enum logic [1:0] {
        SEL_MAX     = 2'b00,  // running maximum of the current window
        SEL_SR      = 2'b01,  // partial maximum left by the previous row
        SEL_MIN     = 2'b10,  // start a fresh window
        SEL_MIN_ALT = 2'b11   // same as SEL_MIN
    } sel_e;

    // Ceiling log2, usable in constant expressions (pointer/counter widths).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/maxpool_datapath_if.sv
// Output stream of the pooling datapath toward the next layer.
// Handshake: a word transfers on every rising clock edge where dout_valid and
// dout_ready are both 1; dout_valid never depends on dout_ready, and dout holds
// the oldest queued pooled result (0 while nothing is queued).
interface maxpool_datapath_if #(
    parameter int N = 16
) ();
    logic [N-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         fifo_full;
    logic         overflow;

    modport master (
        output dout,
        output dout_valid,
        output fifo_full,
        output overflow,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_valid,
        input  fifo_full,
        input  overflow,
        output dout_ready
    );
endinterface

// File: rtl/pool_out_fifo.sv
// Synchronous FIFO holding pooled results until the next layer takes them.
// The head word is registered so the output never passes through the memory
// read path combinationally. A push into a full FIFO succeeds only when a pop
// frees a slot in the same cycle; otherwise the word is dropped and a sticky
// overflow flag is raised.
module pool_out_fifo
    import cnn_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [W-1:0]          wdata,
    input  logic                  ready,
    output logic [W-1:0]          rdata,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic [clog2(DEPTH):0] count
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_next;
    logic [CW-1:0] count_after_pop;
    logic [CW-1:0] count_next;
    logic [W-1:0]  head_next;
    logic          pop;
    logic          push_ok;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // Transfer decisions and the value the head register takes next.
    always_comb begin
        pop             = !empty && ready;
        push_ok         = push && (!full || pop);
        rd_next         = pop ? rd_ptr + AW'(1) : rd_ptr;
        count_after_pop = count - CW'(pop);
        count_next      = count_after_pop + CW'(push_ok);
        head_next       = '0;
        if (count_next != '0) begin
            // The incoming word becomes the head only if nothing older remains.
            if (push_ok && (count_after_pop == '0)) begin
                head_next = wdata;
            end else begin
                head_next = mem[rd_next];
            end
        end
    end

    // Storage array; contents only matter where count says they are valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers, occupancy, registered head and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rdata    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_next;
            count  <= count_next;
            rdata  <= head_next;
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/maxpool_datapath.sv
// Max-pooling datapath stepped pixel-by-pixel by the pooling control FSM.
// Each pixel is compared against a selected candidate (running max, the
// partial max the previous row left for this window, or the minimum value).
// Partial maxima for one row of windows wait in a shift buffer; completed
// window maxima go to an output FIFO.
module maxpool_datapath
    import cnn_pkg::*;
#(
    parameter int N          = 16,
    parameter int M          = 4,
    parameter int P          = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       master_rst,
    input  logic                       ce,
    input  logic [N-1:0]               din,
    input  logic [1:0]                 sel,
    input  logic                       rst_m,
    input  logic                       op_en,
    input  logic                       load_sr,
    input  logic                       global_rst,
    input  logic                       end_op,
    maxpool_datapath_if.master         out_bus,
    output logic                       frame_done,
    output logic [N-1:0]               dbg_max_r,
    output logic [clog2(FIFO_DEPTH):0] dbg_fifo_count
);

    localparam int D = M / P;
    localparam logic [N-1:0] MIN_N = {1'b1, {(N-1){1'b0}}};

    logic [N-1:0] max_r;
    logic [N-1:0] row_buf [D];
    logic [N-1:0] head;
    logic [N-1:0] cand;
    logic [N-1:0] cmp;
    logic         fifo_empty;

    // Oldest entry sits at the far end of the shift chain.
    assign head = row_buf[D-1];

    // Candidate selection and signed compare; a tie keeps the candidate.
    always_comb begin
        cand = MIN_N;
        case (sel_e'(sel))
            SEL_MAX: cand = max_r;
            SEL_SR:  cand = head;
            default: cand = MIN_N;
        endcase
        cmp = ($signed(din) > $signed(cand)) ? din : cand;
    end

    // Running maximum; a frame clear or window restart overrides the update.
    always_ff @(posedge clk or posedge master_rst) begin
        if (master_rst) begin
            max_r <= MIN_N;
        end else if (ce) begin
            if (!global_rst || rst_m) begin
                max_r <= MIN_N;
            end else begin
                max_r <= cmp;
            end
        end
    end

    // Row buffer of per-window partial maxima, cleared on frame clear.
    always_ff @(posedge clk or posedge master_rst) begin
        if (master_rst) begin
            for (int i = 0; i < D; i++) begin
                row_buf[i] <= MIN_N;
            end
        end else if (ce) begin
            if (!global_rst) begin
                for (int i = 0; i < D; i++) begin
                    row_buf[i] <= MIN_N;
                end
            end else if (load_sr) begin
                row_buf[0] <= cmp;
                for (int i = 1; i < D; i++) begin
                    row_buf[i] <= row_buf[i-1];
                end
            end
        end
    end

    // One-cycle end-of-frame pulse for each strobed end_op.
    always_ff @(posedge clk or posedge master_rst) begin
        if (master_rst) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= ce && end_op;
        end
    end

    // The push path ignores the frame clear: the pre-clear result still lands.
    pool_out_fifo #(
        .W     (N),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (master_rst),
        .push     (ce && op_en),
        .wdata    (cmp),
        .ready    (out_bus.dout_ready),
        .rdata    (out_bus.dout),
        .empty    (fifo_empty),
        .full     (out_bus.fifo_full),
        .overflow (out_bus.overflow),
        .count    (dbg_fifo_count)
    );

    assign out_bus.dout_valid = !fifo_empty;
    assign dbg_max_r          = max_r;

endmodule

// File: tb/tb_maxpool_datapath.sv
// Bench for maxpool_datapath: scenario tasks drive the control inputs,
// expected pooled results go into exp_q and are compared as they drain.
module tb_maxpool_datapath;
    import cnn_pkg::*;

    localparam int N  = 16;
    localparam int M  = 4;
    localparam int P  = 2;
    localparam int FD = 4;

    logic                clk = 1'b0;
    logic                master_rst;
    logic                ce;
    logic [N-1:0]        din;
    logic [1:0]          sel;
    logic                rst_m;
    logic                op_en;
    logic                load_sr;
    logic                global_rst;
    logic                end_op;
    logic                frame_done;
    logic [N-1:0]        dbg_max_r;
    logic [clog2(FD):0]  dbg_fifo_count;

    logic [N-1:0] exp_q[$];
    logic [N-1:0] exp_v;
    int           checks = 0;
    int           errors = 0;

    maxpool_datapath_if #(.N(N)) bus ();

    maxpool_datapath #(.N(N), .M(M), .P(P), .FIFO_DEPTH(FD)) dut (
        .clk            (clk),
        .master_rst     (master_rst),
        .ce             (ce),
        .din            (din),
        .sel            (sel),
        .rst_m          (rst_m),
        .op_en          (op_en),
        .load_sr        (load_sr),
        .global_rst     (global_rst),
        .end_op         (end_op),
        .out_bus        (bus.master),
        .frame_done     (frame_done),
        .dbg_max_r      (dbg_max_r),
        .dbg_fifo_count (dbg_fifo_count)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "time limit");
    end

    task automatic set_idle();
        ce         = 1'b0;
        din        = '0;
        sel        = SEL_MAX;
        rst_m      = 1'b0;
        op_en      = 1'b0;
        load_sr    = 1'b0;
        global_rst = 1'b1;
        end_op     = 1'b0;
    endtask

    // One strobed pixel with its control word; returns at the following negedge.
    task automatic drive(input logic [N-1:0] d, input logic [1:0] s, input logic rm,
                         input logic oe, input logic ls, input logic gr, input logic eo);
        ce = 1'b1; din = d; sel = s; rst_m = rm; op_en = oe; load_sr = ls;
        global_rst = gr; end_op = eo;
        @(negedge clk);
        set_idle();
    endtask

    task automatic test_reset();
        master_rst = 1'b1;
        set_idle();
        bus.dout_ready = 1'b0;
        #1;
        checks++;
        if (bus.dout_valid !== 1'b0 || bus.dout !== '0 || bus.fifo_full !== 1'b0 ||
            bus.overflow !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b dout=%h full=%b ovf=%b fd=%b, required 0 0000 0 0 0",
                     bus.dout_valid, bus.dout, bus.fifo_full, bus.overflow, frame_done);
        end
        checks++;
        if (dbg_max_r !== 16'h8000) begin
            errors++;
            $display("FAIL reset_max_r: got %h required 8000", dbg_max_r);
        end
        @(negedge clk);
        master_rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_compare();
        bus.dout_ready = 1'b0;
        drive(16'hFFFD, SEL_MIN, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        exp_q.push_back(16'hFFFD);
        checks++;
        if (bus.dout_valid !== 1'b1 || bus.dout !== 16'hFFFD) begin
            errors++;
            $display("FAIL compare_latency: valid=%b dout=%h, required 1 fffd", bus.dout_valid, bus.dout);
        end
        checks++;
        if (dbg_max_r !== 16'hFFFD) begin
            errors++;
            $display("FAIL compare_max_r: got %h required fffd", dbg_max_r);
        end
        drive(16'd7, SEL_MIN, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(16'd7, SEL_MAX, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        exp_q.push_back(16'd7);
        checks++;
        if (dbg_max_r !== 16'd7) begin
            errors++;
            $display("FAIL compare_tie: max_r got %h required 0007", dbg_max_r);
        end
        // Smaller pixel keeps the running max; rst_m wins over the update.
        drive(16'd3, SEL_MAX, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        exp_q.push_back(16'd7);
        checks++;
        if (dbg_max_r !== 16'h8000) begin
            errors++;
            $display("FAIL compare_rst_m: max_r got %h required 8000", dbg_max_r);
        end
        drive(16'h8001, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        exp_q.push_back(16'h8001);
        checks++;
        if (bus.fifo_full !== 1'b1) begin
            errors++;
            $display("FAIL compare_full: fifo_full got %b required 1", bus.fifo_full);
        end
        bus.dout_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            if (bus.dout_valid) begin
                exp_v = exp_q.pop_front();
                checks++;
                if (bus.dout !== exp_v) begin
                    errors++;
                    $display("FAIL compare_dout: got %h required %h", bus.dout, exp_v);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0 || bus.dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL compare_drain: left %0d valid=%b, required 0 0", exp_q.size(), bus.dout_valid);
            exp_q.delete();
        end
        bus.dout_ready = 1'b0;
    endtask

    task automatic test_frame();
        int frame [M][M];
        int mx;
        logic [1:0] s;
        logic first_col, last_col, first_row, last_row;
        frame = '{'{1, 5, 2, 3}, '{4, 0, 7, 6}, '{9, 8, -1, -2}, '{3, 2, -4, -5}};
        // Reference: plain maximum over each PxP window in raster order.
        for (int wr = 0; wr < M / P; wr++) begin
            for (int wc = 0; wc < M / P; wc++) begin
                mx = frame[wr*P][wc*P];
                for (int y = 0; y < P; y++) begin
                    for (int x = 0; x < P; x++) begin
                        if (frame[wr*P+y][wc*P+x] > mx) mx = frame[wr*P+y][wc*P+x];
                    end
                end
                exp_q.push_back(N'(mx));
            end
        end
        bus.dout_ready = 1'b0;
        for (int r = 0; r < M; r++) begin
            for (int c = 0; c < M; c++) begin
                first_col = (c % P == 0);
                last_col  = (c % P == P - 1);
                first_row = (r % P == 0);
                last_row  = (r % P == P - 1);
                s = !first_col ? SEL_MAX : (first_row ? SEL_MIN : SEL_SR);
                drive(N'(frame[r][c]), s, last_col, last_col && last_row, last_col, 1'b1,
                      (r == M - 1) && (c == M - 1));
            end
        end
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL frame_done_pulse: got %b required 1", frame_done);
        end
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL frame_done_single: got %b required 0", frame_done);
        end
        bus.dout_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            if (bus.dout_valid) begin
                exp_v = exp_q.pop_front();
                checks++;
                if (bus.dout !== exp_v) begin
                    errors++;
                    $display("FAIL frame_dout: got %h required %h", bus.dout, exp_v);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL frame_drain: %0d results missing, required 0", exp_q.size());
            exp_q.delete();
        end
        bus.dout_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [N-1:0] v;
        bus.dout_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            v = N'($urandom_range(0, 65535));
            if (k < FD) exp_q.push_back(v);
            drive(v, SEL_MIN, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            if (k == FD - 1) begin
                checks++;
                if (bus.fifo_full !== 1'b1 || bus.overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_fill: full=%b ovf=%b, required 1 0", bus.fifo_full, bus.overflow);
                end
            end
        end
        checks++;
        if (bus.overflow !== 1'b1 || dbg_fifo_count !== 3'd4) begin
            errors++;
            $display("FAIL bp_overflow: ovf=%b count=%0d, required 1 4", bus.overflow, dbg_fifo_count);
        end
        bus.dout_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            if (bus.dout_valid) begin
                exp_v = exp_q.pop_front();
                checks++;
                if (bus.dout !== exp_v) begin
                    errors++;
                    $display("FAIL bp_dout: got %h required %h", bus.dout, exp_v);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0 || bus.dout_valid !== 1'b0 || bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL bp_after: left %0d valid=%b ovf=%b, required 0 0 1",
                     exp_q.size(), bus.dout_valid, bus.overflow);
            exp_q.delete();
        end
        bus.dout_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.dout_ready = 1'b0;
        drive(16'd11, SEL_MIN, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(16'd22, SEL_MIN, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(16'd33, SEL_MIN, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        #2;
        master_rst = 1'b1;
        #1;
        checks++;
        if (bus.dout_valid !== 1'b0 || bus.overflow !== 1'b0 || dbg_max_r !== 16'h8000 ||
            bus.dout !== '0 || dbg_fifo_count !== '0) begin
            errors++;
            $display("FAIL reset_mid: valid=%b ovf=%b max_r=%h dout=%h count=%0d, required 0 0 8000 0000 0",
                     bus.dout_valid, bus.overflow, dbg_max_r, bus.dout, dbg_fifo_count);
        end
        exp_q.delete();
        @(negedge clk);
        master_rst = 1'b0;
        // Pop while empty must leave the FIFO empty with a zero head.
        bus.dout_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.dout_valid !== 1'b0 || bus.dout !== '0 || dbg_fifo_count !== '0) begin
            errors++;
            $display("FAIL pop_empty: valid=%b dout=%h count=%0d, required 0 0000 0",
                     bus.dout_valid, bus.dout, dbg_fifo_count);
        end
        bus.dout_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] v;
        bus.dout_ready = 1'b0;
        for (int k = 0; k < FD; k++) begin
            v = N'($urandom_range(0, 65535));
            exp_q.push_back(v);
            drive(v, SEL_MIN, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        end
        bus.dout_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            v = N'($urandom_range(0, 65535));
            checks++;
            if (exp_q.size() == 0 || bus.dout_valid !== 1'b1 || bus.dout !== exp_q[0]) begin
                errors++;
                $display("FAIL b2b_head: valid=%b dout=%h, required 1 %h", bus.dout_valid, bus.dout,
                         (exp_q.size() != 0) ? exp_q[0] : '0);
            end
            if (exp_q.size() != 0) exp_v = exp_q.pop_front();
            exp_q.push_back(v);
            drive(v, SEL_MIN, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            checks++;
            if (dbg_fifo_count !== 3'd4 || bus.fifo_full !== 1'b1 || bus.overflow !== 1'b0) begin
                errors++;
                $display("FAIL b2b_occupancy: count=%0d full=%b ovf=%b, required 4 1 0",
                         dbg_fifo_count, bus.fifo_full, bus.overflow);
            end
        end
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            if (bus.dout_valid) begin
                exp_v = exp_q.pop_front();
                checks++;
                if (bus.dout !== exp_v) begin
                    errors++;
                    $display("FAIL b2b_dout: got %h required %h", bus.dout, exp_v);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: %0d results missing, required 0", exp_q.size());
            exp_q.delete();
        end
        bus.dout_ready = 1'b0;
    endtask

    task automatic test_global_rst();
        bus.dout_ready = 1'b0;
        // Leave a large partial max in the row buffer, then a large running max.
        drive(16'd100, SEL_MIN, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(16'd90,  SEL_MAX, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(16'd120, SEL_MIN, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        // Frame clear with a same-cycle push: the pre-clear result (120) lands.
        drive(16'd10, SEL_MAX, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(16'd120);
        checks++;
        if (dbg_max_r !== 16'h8000) begin
            errors++;
            $display("FAIL grst_max_r: got %h required 8000", dbg_max_r);
        end
        // Shift once so the entry that held 100 reaches the head, then read it.
        drive(16'hFFF9, SEL_MIN, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(16'hFFF7, SEL_SR, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        exp_q.push_back(16'hFFF7);
        // frame_done: one pulse per strobe, none without ce.
        drive(16'd0, SEL_MAX, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL grst_frame_done: got %b required 1", frame_done);
        end
        end_op = 1'b1;
        @(negedge clk);
        end_op = 1'b0;
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL frame_done_no_ce: got %b required 0", frame_done);
        end
        bus.dout_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            if (bus.dout_valid) begin
                exp_v = exp_q.pop_front();
                checks++;
                if (bus.dout !== exp_v) begin
                    errors++;
                    $display("FAIL grst_dout: got %h required %h", bus.dout, exp_v);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL grst_drain: %0d results missing, required 0", exp_q.size());
            exp_q.delete();
        end
        bus.dout_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_compare();
        test_frame();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_global_rst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
